fetch_inst_buffer: RTL and testbench



---
 rtl/fetch_inst_buffer.sv | 112 +++++++++++
 tb/tb_fetch_inst_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular FIFO between fetch stage 2 and decode.
// Accepts up to four packets per cycle and presents the four oldest in program order.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module fetch_inst_buffer #(
    parameter int DEPTH    = 16,
    parameter int PKT_W    = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1,
    parameter int FETCH_BW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     fs2Ready_i,
    input  logic                     inst0Valid_i,
    input  logic                     inst1Valid_i,
    input  logic                     inst2Valid_i,
    input  logic                     inst3Valid_i,
    input  logic [PKT_W-1:0]         inst0Packet_i,
    input  logic [PKT_W-1:0]         inst1Packet_i,
    input  logic [PKT_W-1:0]         inst2Packet_i,
    input  logic [PKT_W-1:0]         inst3Packet_i,
    input  logic                     decodeStall_i,
    output logic                     instBufferFull_o,
    output logic                     inst0Valid_o,
    output logic                     inst1Valid_o,
    output logic                     inst2Valid_o,
    output logic                     inst3Valid_o,
    output logic [PKT_W-1:0]         inst0Packet_o,
    output logic [PKT_W-1:0]         inst1Packet_o,
    output logic [PKT_W-1:0]         inst2Packet_o,
    output logic [PKT_W-1:0]         inst3Packet_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] in_pkt [4];
    logic [PKT_W-1:0] out_pkt [4];
    logic [3:0]       in_vld;
    logic [2:0]       n_wr;
    logic [CW-1:0]    n_wr_eff, n_rd;
    logic             full, wr_en, rd_en;

    assign in_vld = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign in_pkt[0] = inst0Packet_i;
    assign in_pkt[1] = inst1Packet_i;
    assign in_pkt[2] = inst2Packet_i;
    assign in_pkt[3] = inst3Packet_i;

    // Only the contiguous valid prefix starting at slot 0 is written.
    assign n_wr = !in_vld[0] ? 3'd0 : !in_vld[1] ? 3'd1 : !in_vld[2] ? 3'd2 : !in_vld[3] ? 3'd3 : 3'd4;

    // Full looks only at registered count, so there is no path from decodeStall_i.
    assign full     = count_q > CW'(DEPTH - FETCH_BW);
    assign wr_en    = fs2Ready_i & ~full & ~flush_i;
    assign rd_en    = ~decodeStall_i & ~flush_i;
    assign n_wr_eff = wr_en ? CW'(n_wr) : '0;
    assign n_rd     = !rd_en ? '0 : (count_q > CW'(FETCH_BW)) ? CW'(FETCH_BW) : count_q;

    always_comb begin
        head_d  = flush_i ? '0 : head_q + AW'(n_rd);
        tail_d  = flush_i ? '0 : tail_q + AW'(n_wr_eff);
        count_d = flush_i ? '0 : count_q + n_wr_eff - n_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (wr_en && 3'(k) < n_wr)
                mem_q[tail_q + AW'(k)] <= in_pkt[k];
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            out_pkt[k] = mem_q[head_q + AW'(k)];
    end

    assign instBufferFull_o = full;
    assign count_o          = count_q;
    assign inst0Valid_o     = count_q > CW'(0);
    assign inst1Valid_o     = count_q > CW'(1);
    assign inst2Valid_o     = count_q > CW'(2);
    assign inst3Valid_o     = count_q > CW'(3);
    assign inst0Packet_o    = out_pkt[0];
    assign inst1Packet_o    = out_pkt[1];
    assign inst2Packet_o    = out_pkt[2];
    assign inst3Packet_o    = out_pkt[3];

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: directed vector table plus a packet queue scoreboard
// for fetch_inst_buffer, with hand sequences for reset, flush and async reset.
module tb_fetch_inst_buffer;

    localparam int PW = 101;

    typedef struct {
        bit       fs2;
        bit [3:0] v;
        bit       stall;
        bit       flush;
        int       ec;
        bit       ef;
    } vec_t;

    logic          clk, reset, flush_i, fs2_i, stall_i, full_o;
    logic [3:0]    vin;
    logic          vo [4];
    logic [PW-1:0] pkt_i [4];
    logic [PW-1:0] pkt_o [4];
    logic [4:0]    count_o;

    logic [31:0] q [$];
    logic [31:0] next_pc;
    vec_t        tbl [$];
    int          n_cmp, n_bad;

    fetch_inst_buffer #(.DEPTH(16), .PKT_W(PW), .FETCH_BW(4)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .fs2Ready_i(fs2_i),
        .inst0Valid_i(vin[3]), .inst1Valid_i(vin[2]), .inst2Valid_i(vin[1]), .inst3Valid_i(vin[0]),
        .inst0Packet_i(pkt_i[0]), .inst1Packet_i(pkt_i[1]), .inst2Packet_i(pkt_i[2]), .inst3Packet_i(pkt_i[3]),
        .decodeStall_i(stall_i), .instBufferFull_o(full_o),
        .inst0Valid_o(vo[0]), .inst1Valid_o(vo[1]), .inst2Valid_o(vo[2]), .inst3Valid_o(vo[3]),
        .inst0Packet_o(pkt_o[0]), .inst1Packet_o(pkt_o[1]), .inst2Packet_o(pkt_o[2]), .inst3Packet_o(pkt_o[3]),
        .count_o(count_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        logic [31:0] tgt;
        tgt = pc + 32'd4;
        return {~pc, pc, tgt, pc[6:3], pc[3]};
    endfunction

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic void add(input bit fs2, input bit [3:0] v, input bit stall, input bit flush,
                                input int ec, input bit ef);
        vec_t t;
        t.fs2 = fs2; t.v = v; t.stall = stall; t.flush = flush; t.ec = ec; t.ef = ef;
        tbl.push_back(t);
    endfunction

    task automatic check_state(input string tag, input int ec, input bit ef);
        chk({tag, " count"}, 128'(count_o), 128'(ec));
        chk({tag, " full"}, 128'(full_o), 128'(ef));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s valid%0d", tag, k), 128'(vo[k]), 128'(q.size() > k));
            if (q.size() > k)
                chk($sformatf("%s pkt%0d", tag, k), 128'(pkt_o[k]), 128'(mk(q[k])));
        end
    endtask

    task automatic step(input vec_t t, input string tag);
        int nw, nr;
        bit fm;
        fs2_i = t.fs2; vin = t.v; stall_i = t.stall; flush_i = t.flush;
        for (int k = 0; k < 4; k++) pkt_i[k] = mk(next_pc + 32'(8 * k));
        fm = q.size() > 12;
        nw = !t.v[3] ? 0 : !t.v[2] ? 1 : !t.v[1] ? 2 : !t.v[0] ? 3 : 4;
        nr = (!t.stall && !t.flush) ? ((q.size() > 4) ? 4 : q.size()) : 0;
        for (int k = 0; k < nr; k++) void'(q.pop_front());
        if (t.fs2 && !fm && !t.flush) begin
            for (int k = 0; k < nw; k++) q.push_back(next_pc + 32'(8 * k));
            next_pc = next_pc + 32'(8 * nw);
        end
        if (t.flush) q.delete();
        @(posedge clk);
        #1;
        check_state(tag, t.ec, t.ef);
    endtask

    initial begin
        vec_t t;
        logic [31:0] p;
        n_cmp = 0; n_bad = 0; next_pc = 32'h100;
        reset = 0; flush_i = 0; fs2_i = 1; vin = 4'hF; stall_i = 0;
        for (int k = 0; k < 4; k++) pkt_i[k] = mk(32'hdead0000 + 32'(k));

        repeat (3) @(posedge clk);
        #1;
        check_state("in_reset", 0, 0);
        reset = 1;

        add(1,4'hF,1,0, 4,0);  add(0,4'h0,0,0, 0,0);
        add(1,4'hC,1,0, 2,0);  add(1,4'hE,1,0, 5,0);  add(1,4'hA,1,0, 6,0);
        add(0,4'hF,1,0, 6,0);  add(0,4'h0,0,0, 2,0);  add(0,4'h0,0,0, 0,0);
        add(0,4'h0,0,0, 0,0);
        add(1,4'hF,1,0, 4,0);  add(1,4'hF,1,0, 8,0);  add(1,4'hF,1,0, 12,0);
        add(1,4'hF,1,0, 16,1); add(1,4'hF,1,0, 16,1);
        add(0,4'h0,0,0, 12,0); add(0,4'h0,0,0, 8,0);  add(0,4'h0,0,0, 4,0);
        add(0,4'h0,0,0, 0,0);
        add(1,4'h8,1,0, 1,0);  add(1,4'hE,1,0, 4,0);  add(1,4'hE,1,0, 7,0);
        add(1,4'hE,1,0, 10,0); add(1,4'hE,1,0, 13,1); add(1,4'hE,1,0, 13,1);
        add(1,4'hF,0,0, 9,0);  add(1,4'hF,0,0, 9,0);
        add(0,4'h0,0,0, 5,0);  add(0,4'h0,0,0, 1,0);  add(0,4'h0,0,0, 0,0);
        add(1,4'hF,1,0, 4,0);  add(1,4'hF,1,0, 8,0);  add(1,4'hC,1,0, 10,0);
        for (int i = 0; i < 8; i++) add(1,4'hF,0,0, 10,0);
        add(0,4'h0,0,0, 6,0);  add(1,4'hE,1,0, 9,0);
        add(1,4'hF,0,1, 0,0);  add(1,4'hC,1,0, 2,0);
        add(1,4'hF,1,0, 6,0);  add(1,4'h8,1,0, 7,0);

        for (int i = 0; i < tbl.size(); i++) begin
            p = next_pc;
            step(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("first pc0", 128'(pkt_o[0][68:37]), 128'h100);
                chk("first pc3", 128'(pkt_o[3][68:37]), 128'h118);
            end
            if (i == 43) chk("after_flush pc0", 128'(pkt_o[0][68:37]), 128'(p));
        end

        // Asynchronous reset between edges at count 7.
        #3;
        reset = 0;
        #1;
        q.delete();
        check_state("async_reset", 0, 0);
        fs2_i = 1; vin = 4'hF; stall_i = 1;
        @(posedge clk);
        #1;
        check_state("reset_held", 0, 0);
        reset = 1;
        t.fs2 = 1; t.v = 4'hF; t.stall = 1; t.flush = 0; t.ec = 4; t.ef = 0;
        p = next_pc;
        step(t, "post_reset");
        chk("post_reset pc0", 128'(pkt_o[0][68:37]), 128'(p));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
